// File: rtl/aes_pkg.sv
// Shared constants and FSM state encoding for the AES-128 round sequencer.
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int AES128_RW = $clog2(AES128_NR + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_WAIT = 3'd1,
    ST_ADDKEY   = 3'd2,
    ST_SUB      = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_MIX      = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps an external datapath through the FIPS-197
// round order with one-cycle enables and fetches each round key by handshake.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int RW = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          start_ready,
  input  logic          abort,
  output logic          key_req,
  input  logic          key_ack,
  output logic [RW-1:0] round,
  output logic          load_en,
  output logic          add_en,
  output logic          sub_en,
  output logic          shift_en,
  output logic          mix_en,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output state_t        dbg_state
);

  localparam logic [RW-1:0] LP_NR = RW'(NR);

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_round;
  logic [RW-1:0] w_round_nxt;
  logic          w_last;
  logic          w_accept;

  assign w_last   = (r_round == LP_NR);
  assign w_accept = (r_state == ST_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_next;
      r_round <= w_round_nxt;
    end
  end

  // abort overrides every transition, including a start seen in IDLE
  always_comb begin
    w_next      = r_state;
    w_round_nxt = r_round;
    if (abort) begin
      w_next      = ST_IDLE;
      w_round_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next      = ST_KEY_WAIT;
            w_round_nxt = '0;
          end
        end
        ST_KEY_WAIT: if (key_ack) w_next = ST_ADDKEY;
        ST_ADDKEY: begin
          if (w_last) begin
            w_next = ST_DONE;
          end else begin
            w_next      = ST_SUB;
            w_round_nxt = r_round + RW'(1);
          end
        end
        ST_SUB:   w_next = ST_SHIFT;
        ST_SHIFT: w_next = w_last ? ST_KEY_WAIT : ST_MIX;
        ST_MIX:   w_next = ST_KEY_WAIT;
        ST_DONE:  if (out_ready) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Handshakes are valid/ready: a transfer happens on a rising edge where both
  // are high (start/start_ready, key_req/key_ack, out_valid/out_ready); valid
  // holds until that edge and ready never depends on the partner's valid.
  assign start_ready = (r_state == ST_IDLE);
  assign load_en     = w_accept && rst_n;
  assign key_req     = (r_state == ST_KEY_WAIT);
  assign add_en      = (r_state == ST_ADDKEY);
  assign sub_en      = (r_state == ST_SUB);
  assign shift_en    = (r_state == ST_SHIFT);
  assign mix_en      = (r_state == ST_MIX);
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign round       = r_round;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: enable-driven AES datapath model, key/consumer
// responders, vector table plus abort and mid-block reset sequences.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic key_ack = 1'b0;
  logic out_ready = 1'b0;
  logic start_ready, key_req, load_en, add_en, sub_en, shift_en, mix_en, busy, out_valid;
  logic [3:0] round;
  state_t dbg_state;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .abort(abort), .key_req(key_req), .key_ack(key_ack), .round(round),
    .load_en(load_en), .add_en(add_en), .sub_en(sub_en), .shift_en(shift_en),
    .mix_en(mix_en), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int key_dly;
    int rdy_dly;
    bit inject;
    int lat;
  } vec_t;

  vec_t vecs[6];
  logic [127:0] exp_q[$];
  logic [7:0] sbox[256];
  logic [127:0] cur_pt;
  logic [127:0] cur_rk[11];
  int cfg_key_dly = -1;
  int cfg_rdy_dly = 0;
  bit cfg_inject = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[127-8*(c*4+rr) -: 8] = s[127-8*(((c+rr)%4)*4+rr) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(c*4+0) -: 8]; a1 = s[127-8*(c*4+1) -: 8];
      a2 = s[127-8*(c*4+2) -: 8]; a3 = s[127-8*(c*4+3) -: 8];
      r[127-8*(c*4+0) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[127-8*(c*4+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[127-8*(c*4+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[127-8*(c*4+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int rn);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rn], w[4*rn+1], w[4*rn+2], w[4*rn+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r < NR; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ round_key(key, r);
    return shift_rows(sub_bytes(s)) ^ round_key(key, NR);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      s = inv ^ 8'h63;
      for (int k = 1; k < 5; k++) s = s ^ 8'(d >> (8 - k));
      sbox[x] = s;
    end
  endtask

  // ---------------- key_expansion and consumer responders ----------------
  int kw_cnt = 0;
  int rdy_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (cfg_key_dly < 0) key_ack = 1'b1;
    else if (key_req) begin
      key_ack = (kw_cnt == cfg_key_dly);
      kw_cnt++;
    end else begin
      kw_cnt = 0;
      key_ack = cfg_inject && sub_en;
    end
    if (out_valid) begin
      out_ready = (rdy_cnt >= cfg_rdy_dly);
      rdy_cnt++;
    end else begin
      rdy_cnt = 0;
      out_ready = cfg_inject;
    end
  end

  // ---------------- monitor: datapath model and scoreboard ----------------
  logic [127:0] model_st = '0;
  int n_add = 0, n_sub = 0, n_shift = 0, n_mix = 0, n_en_total = 0;
  int order_err = 0, onehot_err = 0, stab_err = 0, mix_nr_err = 0;
  int lat_cnt = 0, meas_lat = -1, ov_cycles = 0, n_done = 0;
  bit lat_run = 0, prev_pop = 0, prev_kreq = 0, prev_ack = 0, prev_rstn = 0;
  logic [3:0] prev_round = '0;

  always @(negedge clk) begin : mon
    int en;
    en = int'(load_en) + int'(add_en) + int'(sub_en) + int'(shift_en) + int'(mix_en);
    n_en_total += en;
    if (en > 1) onehot_err++;
    if (load_en) begin
      model_st = cur_pt;
      n_add = 0; n_sub = 0; n_shift = 0; n_mix = 0;
      lat_cnt = -1; lat_run = 1; meas_lat = -1; ov_cycles = 0;
    end else if (lat_run) begin
      lat_cnt++;
      if (out_valid) begin meas_lat = lat_cnt; lat_run = 0; end
    end
    if (add_en) begin
      if (round != 4'(n_add)) order_err++;
      if (round <= 4'd10) model_st = model_st ^ cur_rk[round];
      n_add++;
    end
    if (sub_en) begin model_st = sub_bytes(model_st); n_sub++; end
    if (shift_en) begin model_st = shift_rows(model_st); n_shift++; end
    if (mix_en) begin
      if (round == 4'(NR)) mix_nr_err++;
      model_st = mix_cols(model_st); n_mix++;
    end
    if (prev_kreq && !prev_ack && prev_rstn && rst_n && !key_req) stab_err++;
    if (prev_kreq && key_req && round != prev_round) stab_err++;
    if (out_valid) begin
      ov_cycles++;
      chk("start_ready_in_done", start_ready, 1'b0);
    end
    if (prev_pop) chk("idle_after_take", {busy, out_valid, start_ready}, 3'b001);
    prev_pop = out_valid && out_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got output with empty queue, required none");
      end else chk("ciphertext", model_st, exp_q.pop_front());
      n_done++;
    end
    prev_kreq = key_req; prev_ack = key_ack; prev_rstn = rst_n; prev_round = round;
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_block(input vec_t v);
    cfg_key_dly = v.key_dly;
    cfg_rdy_dly = v.rdy_dly;
    cfg_inject  = v.inject;
    cur_pt = v.pt;
    for (int r = 0; r <= NR; r++) cur_rk[r] = round_key(v.key, r);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("load_en_at_accept", {load_en, start_ready}, 2'b11);
    exp_q.push_back(v.ct);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {busy, start_ready, key_req, round}, 7'b1010000);
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int d0;
    d0 = n_done;
    start_block(v);
    if (v.inject) begin
      repeat (6) @(posedge clk);
      #1 start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 600 && n_done == d0; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_done"}, n_done - d0, 1);
    chk({tag, "_latency"}, meas_lat, v.lat);
    chk({tag, "_ov_hold"}, ov_cycles, v.rdy_dly + 1);
    chk({tag, "_counts"}, {8'(n_add), 8'(n_sub), 8'(n_shift), 8'(n_mix)},
        {8'd11, 8'd10, 8'd10, 8'd9});
    chk({tag, "_round_seq"}, order_err, 0);
    chk({tag, "_protocol"}, {16'(onehot_err), 16'(mix_nr_err), 16'(stab_err)}, 48'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t hv;
    int e0, d;
    logic [127:0] rp, rk;
    build_sbox();
    vecs[0] = '{FIPS_PT, FIPS_KEY, FIPS_CT, -1, 0, 1'b0, 51};
    vecs[1] = '{FIPS_PT, FIPS_KEY, FIPS_CT, 3, 0, 1'b0, 84};
    rp = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    vecs[2] = '{rp, rk, aes_ref(rp, rk), 0, 5, 1'b0, 51};
    vecs[3] = '{FIPS_PT, FIPS_KEY, FIPS_CT, 0, 0, 1'b1, 51};
    rp = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    vecs[4] = '{rp, rk, aes_ref(rp, rk), 1, 2, 1'b0, 62};
    d = $urandom_range(0, 4);
    rp = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    vecs[5] = '{rp, rk, aes_ref(rp, rk), d, $urandom_range(0, 3), 1'b0, 51 + 11 * d};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {start_ready, busy, key_req, load_en, add_en, sub_en, shift_en, mix_en, out_valid, round},
        13'h1000);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // abort together with start in IDLE must not be accepted
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_blocks_load", load_en, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_blocks_accept", {busy, start_ready}, 2'b01);

    // abort in round 5 MIX
    hv = vecs[0];
    start_block(hv);
    e0 = 0;
    for (int i = 0; i < 200 && e0 == 0; i++) begin
      @(negedge clk);
      if (mix_en && round == 4'd5) e0 = 1;
    end
    chk("reach_r5_mix", e0, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_to_idle", {busy, start_ready, out_valid, round}, 7'b0100000);
    chk("abort_dbg_state", dbg_state, ST_IDLE);
    e0 = n_en_total;
    repeat (5) @(negedge clk);
    chk("abort_no_enables", n_en_total - e0, 0);
    void'(exp_q.pop_front());
    run_block(vecs[0], "after_abort");

    // asynchronous reset in round 3 KEY_WAIT
    hv = vecs[0];
    hv.key_dly = 2;
    hv.lat = 73;
    start_block(hv);
    e0 = 0;
    for (int i = 0; i < 200 && e0 == 0; i++) begin
      @(negedge clk);
      if (key_req && round == 4'd3) e0 = 1;
    end
    chk("reach_r3_keywait", e0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {start_ready, busy, key_req, load_en, add_en, sub_en, shift_en, mix_en, out_valid, round},
        13'h1000);
    start = 1'b1;
    e0 = n_en_total;
    repeat (3) @(negedge clk);
    chk("reset_no_enables", n_en_total - e0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    run_block(vecs[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
